// File: rtl/dvs_saer_emu_if.sv
// Event-load and SAER readout signals of the DVS sensor emulator.
// slave = emulator side, master = host/loader side.
interface dvs_saer_emu_if #(
    parameter int NCH = 4
);
    logic           wr_vld_i;
    logic           wr_rdy_o;
    logic [7:0]     wr_y_i;
    logic [7:0]     wr_x_i;
    logic [NCH-1:0] wr_on_i;
    logic [NCH-1:0] wr_off_i;
    logic           wr_eof_i;

    logic           saer_yclk_i;
    logic           saer_xclk_i;
    logic           saer_sxy_i;
    logic           saer_ynrst_i;
    logic [7:0]     saer_xydata_o;
    logic [NCH-1:0] saer_on_o;
    logic [NCH-1:0] saer_off_o;

    modport slave (
        input  wr_vld_i, wr_y_i, wr_x_i, wr_on_i, wr_off_i, wr_eof_i,
        input  saer_yclk_i, saer_xclk_i, saer_sxy_i, saer_ynrst_i,
        output wr_rdy_o, saer_xydata_o, saer_on_o, saer_off_o
    );

    modport master (
        output wr_vld_i, wr_y_i, wr_x_i, wr_on_i, wr_off_i, wr_eof_i,
        output saer_yclk_i, saer_xclk_i, saer_sxy_i, saer_ynrst_i,
        input  wr_rdy_o, saer_xydata_o, saer_on_o, saer_off_o
    );
endinterface

// File: rtl/dvs_saer_emu.sv
// DVS sensor emulator: replays a loaded event list over the row/column-scanned
// SAER readout protocol, presenting addresses as 4-of-8 codes.
module dvs_saer_emu #(
    parameter int XDIM  = 52,
    parameter int YDIM  = 66,
    parameter int NCH   = 4,
    parameter int DEPTH = 256,
    parameter int LOOP  = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     run_i,
    dvs_saer_emu_if.slave            bus,
    output logic [$clog2(DEPTH):0]   ev_count_o,
    output logic [15:0]              frame_cnt_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] cnt_t;

    typedef struct packed {
        logic [7:0]     y;
        logic [7:0]     x;
        logic [NCH-1:0] on;
        logic [NCH-1:0] off;
        logic           eof;
    } ev_t;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_YCLK,
        YDATA,
        WAIT_XCLK,
        XDATA,
        XEND,
        YEND,
        WAIT_LAST_YCLK,
        DONE
    } state_t;

    // i-th byte with exactly four ones, counting down from 0xF0; 70 codes total.
    function automatic logic [7:0] code_of(input logic [7:0] idx);
        logic [7:0] cnt;
        logic [7:0] res;
        logic [7:0] vb;
        cnt = '0;
        res = '0;
        for (int v = 255; v >= 0; v--) begin
            vb = 8'(v);
            if ($countones(vb) == 4) begin
                if (cnt == idx) res = vb;
                cnt = cnt + 8'd1;
            end
        end
        return res;
    endfunction

    ev_t            mem_q [DEPTH];

    state_t         state_q;
    cnt_t           ev_count_q;
    cnt_t           ptr_q;
    cnt_t           fstart_q;
    logic           fex_q;
    logic [15:0]    frame_cnt_q;
    logic           yclk_q;
    logic           xclk_q;
    logic [7:0]     xy_q;
    logic [NCH-1:0] on_q;
    logic [NCH-1:0] off_q;

    logic           wr_rdy;
    logic           wr_fire;
    logic           yfall;
    logic           xfall;
    logic           ynrst;
    logic           sxy;
    ev_t            cur;
    logic [AW-1:0]  nxt_idx;
    logic [7:0]     nxt_y;
    logic           cur_eof;
    logic           row_last;
    cnt_t           ev_count_d;

    assign wr_rdy   = !rst_i && !run_i && (ev_count_q < cnt_t'(DEPTH));
    assign wr_fire  = bus.wr_vld_i && wr_rdy;
    assign ev_count_d = wr_fire ? ev_count_q + 1'b1 : ev_count_q;

    assign yfall    = yclk_q && !bus.saer_yclk_i;
    assign xfall    = xclk_q && !bus.saer_xclk_i;
    assign ynrst    = bus.saer_ynrst_i;
    assign sxy      = bus.saer_sxy_i;

    // The last loaded entry always closes a frame, whatever its stored flag says.
    assign cur      = mem_q[ptr_q[AW-1:0]];
    assign nxt_idx  = ptr_q[AW-1:0] + 1'b1;
    assign nxt_y    = mem_q[nxt_idx].y;
    assign cur_eof  = cur.eof || (ptr_q == ev_count_q - 1'b1);
    assign row_last = cur_eof || (nxt_y != cur.y);

    // Event memory is never cleared; ev_count_q alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_fire) begin
            mem_q[ev_count_q[AW-1:0]] <= '{y:   bus.wr_y_i,
                                           x:   bus.wr_x_i,
                                           on:  bus.wr_on_i,
                                           off: bus.wr_off_i,
                                           eof: bus.wr_eof_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            ev_count_q  <= '0;
            ptr_q       <= '0;
            fstart_q    <= '0;
            fex_q       <= 1'b0;
            frame_cnt_q <= '0;
            yclk_q      <= 1'b0;
            xclk_q      <= 1'b0;
            xy_q        <= '0;
            on_q        <= '0;
            off_q       <= '0;
        end else begin
            yclk_q     <= bus.saer_yclk_i;
            xclk_q     <= bus.saer_xclk_i;
            ev_count_q <= ev_count_d;

            // Outputs follow the current state/pointer, so they trail them by a cycle.
            xy_q  <= '0;
            on_q  <= '0;
            off_q <= '0;
            case (state_q)
                YDATA: xy_q <= code_of(cur.y);
                XDATA: begin
                    xy_q  <= code_of(cur.x);
                    on_q  <= cur.on;
                    off_q <= cur.off;
                end
                XEND:  xy_q <= code_of(8'(XDIM));
                YEND:  xy_q <= code_of(8'(YDIM));
                default: ;
            endcase

            if (!run_i) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (ev_count_q != '0) begin
                            state_q  <= WAIT_YCLK;
                            ptr_q    <= '0;
                            fstart_q <= '0;
                            fex_q    <= 1'b0;
                        end
                    end
                    WAIT_YCLK, YDATA, WAIT_XCLK, XDATA, XEND: begin
                        // A host-side row reset restarts the current frame from its first event.
                        if (!ynrst) begin
                            state_q <= WAIT_YCLK;
                            ptr_q   <= fstart_q;
                            fex_q   <= 1'b0;
                        end else begin
                            case (state_q)
                                WAIT_YCLK: if (yfall) state_q <= fex_q ? YEND : YDATA;
                                YDATA:     if (sxy) state_q <= WAIT_XCLK;
                                WAIT_XCLK: if (xfall) state_q <= XDATA;
                                XDATA: begin
                                    if (xfall) begin
                                        if (row_last) state_q <= XEND;
                                        else          ptr_q   <= ptr_q + 1'b1;
                                    end
                                end
                                default: begin
                                    if (!sxy) begin
                                        ptr_q   <= ptr_q + 1'b1;
                                        fex_q   <= cur_eof;
                                        state_q <= WAIT_YCLK;
                                    end
                                end
                            endcase
                        end
                    end
                    YEND: if (!ynrst) state_q <= WAIT_LAST_YCLK;
                    WAIT_LAST_YCLK: begin
                        if (yfall) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                            fex_q       <= 1'b0;
                            if (ptr_q >= ev_count_q) begin
                                if (LOOP != 0) begin
                                    ptr_q    <= '0;
                                    fstart_q <= '0;
                                    state_q  <= WAIT_YCLK;
                                end else begin
                                    state_q  <= DONE;
                                end
                            end else begin
                                fstart_q <= ptr_q;
                                state_q  <= WAIT_YCLK;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.wr_rdy_o      = wr_rdy;
    assign bus.saer_xydata_o = xy_q;
    assign bus.saer_on_o     = on_q;
    assign bus.saer_off_o    = off_q;
    assign ev_count_o        = ev_count_q;
    assign frame_cnt_o       = frame_cnt_q;
    assign busy_o            = (state_q != IDLE) && (state_q != DONE);
    assign done_o            = (state_q == DONE);
endmodule

// File: tb/tb_dvs_saer_emu.sv
// Directed bench: a LOOP=1 and a LOOP=0 emulator driven by the same host stimulus.
module tb_dvs_saer_emu;
    logic clk = 1'b0;
    logic rst;
    logic run;
    int   n_chk = 0;
    int   n_bad = 0;

    logic [8:0]  evc1, evc0;
    logic [15:0] frm1, frm0;
    logic        busy1, busy0, done1, done0;

    dvs_saer_emu_if #(.NCH(4)) bus  ();
    dvs_saer_emu_if #(.NCH(4)) bus0 ();

    assign bus0.wr_vld_i     = bus.wr_vld_i;
    assign bus0.wr_y_i       = bus.wr_y_i;
    assign bus0.wr_x_i       = bus.wr_x_i;
    assign bus0.wr_on_i      = bus.wr_on_i;
    assign bus0.wr_off_i     = bus.wr_off_i;
    assign bus0.wr_eof_i     = bus.wr_eof_i;
    assign bus0.saer_yclk_i  = bus.saer_yclk_i;
    assign bus0.saer_xclk_i  = bus.saer_xclk_i;
    assign bus0.saer_sxy_i   = bus.saer_sxy_i;
    assign bus0.saer_ynrst_i = bus.saer_ynrst_i;

    dvs_saer_emu #(.LOOP(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .run_i(run), .bus(bus),
        .ev_count_o(evc1), .frame_cnt_o(frm1), .busy_o(busy1), .done_o(done1)
    );

    dvs_saer_emu #(.LOOP(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .run_i(run), .bus(bus0),
        .ev_count_o(evc0), .frame_cnt_o(frm0), .busy_o(busy0), .done_o(done0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] y, input logic [7:0] x,
                      input logic [3:0] on, input logic [3:0] off, input logic eof);
        bus.wr_vld_i = 1'b1;
        bus.wr_y_i   = y;
        bus.wr_x_i   = x;
        bus.wr_on_i  = on;
        bus.wr_off_i = off;
        bus.wr_eof_i = eof;
        step(1);
        bus.wr_vld_i = 1'b0;
    endtask

    task automatic yfall();
        bus.saer_yclk_i = 1'b1;
        step(3);
        bus.saer_yclk_i = 1'b0;
        step(4);
    endtask

    task automatic xfall();
        bus.saer_xclk_i = 1'b1;
        step(3);
        bus.saer_xclk_i = 1'b0;
        step(4);
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        bus.wr_vld_i = 1'b0;
        bus.wr_y_i = '0; bus.wr_x_i = '0; bus.wr_on_i = '0; bus.wr_off_i = '0; bus.wr_eof_i = 1'b0;
        bus.saer_yclk_i = 1'b0; bus.saer_xclk_i = 1'b0;
        bus.saer_sxy_i = 1'b0;  bus.saer_ynrst_i = 1'b1;

        // reset state
        step(1);
        chk("rdy_in_rst", int'(bus.wr_rdy_o), 0);
        step(2);
        chk("rst_evc", int'(evc1), 0);
        chk("rst_frm", int'(frm1), 0);
        chk("rst_busy", int'(busy1), 0);
        chk("rst_done", int'(done1), 0);
        chk("rst_xy", int'(bus.saer_xydata_o), 0);
        rst = 1'b0;
        step(1);
        chk("rdy_idle", int'(bus.wr_rdy_o), 1);

        // two events on one row, second closes the frame
        wr(8'd3, 8'd5, 4'h1, 4'h0, 1'b0);
        wr(8'd3, 8'd7, 4'h0, 4'h0, 1'b1);
        chk("load_evc", int'(evc1), 2);
        run = 1'b1;
        step(4);
        chk("run_busy", int'(busy1), 1);
        chk("run_rdy", int'(bus.wr_rdy_o), 0);
        chk("wait_xy", int'(bus.saer_xydata_o), 0);
        yfall();
        chk("y3_code", int'(bus.saer_xydata_o), 'hE2);
        bus.saer_sxy_i = 1'b1;
        step(4);
        xfall();
        chk("x5_code", int'(bus.saer_xydata_o), 'hD8);
        chk("x5_on", int'(bus.saer_on_o), 1);
        xfall();
        chk("x7_code", int'(bus.saer_xydata_o), 'hD2);
        chk("x7_on", int'(bus.saer_on_o), 0);
        xfall();
        chk("xend_code", int'(bus.saer_xydata_o), 'h4D);
        bus.saer_sxy_i = 1'b0;
        step(4);
        chk("after_xend_xy", int'(bus.saer_xydata_o), 0);
        yfall();
        chk("yend_code", int'(bus.saer_xydata_o), 'h1D);
        bus.saer_ynrst_i = 1'b0;
        step(4);
        chk("wlast_xy", int'(bus.saer_xydata_o), 0);
        yfall();
        bus.saer_ynrst_i = 1'b1;
        step(2);
        chk("frm1", int'(frm1), 1);
        chk("loop_busy", int'(busy1), 1);
        chk("l0_frm", int'(frm0), 1);
        chk("l0_done", int'(done0), 1);
        chk("l0_busy", int'(busy0), 0);
        chk("l0_xy", int'(bus0.saer_xydata_o), 0);
        yfall();
        chk("replay_y3", int'(bus.saer_xydata_o), 'hE2);
        chk("l0_hold_xy", int'(bus0.saer_xydata_o), 0);
        chk("l0_hold_done", int'(done0), 1);

        // reset while presenting x data
        bus.saer_sxy_i = 1'b1;
        step(4);
        xfall();
        chk("pre_rst_x5", int'(bus.saer_xydata_o), 'hD8);
        rst = 1'b1;
        step(1);
        chk("mrst_xy", int'(bus.saer_xydata_o), 0);
        chk("mrst_on", int'(bus.saer_on_o), 0);
        chk("mrst_busy", int'(busy1), 0);
        chk("mrst_evc", int'(evc1), 0);
        rst = 1'b0;
        run = 1'b0;
        bus.saer_sxy_i = 1'b0;
        step(2);

        // two rows; row reset during second row's x data rewinds to first row
        wr(8'd3, 8'd5, 4'h1, 4'h0, 1'b0);
        wr(8'd4, 8'd9, 4'h0, 4'h2, 1'b1);
        run = 1'b1;
        step(4);
        yfall();
        chk("r1_y3", int'(bus.saer_xydata_o), 'hE2);
        bus.saer_sxy_i = 1'b1;
        step(4);
        xfall();
        chk("r1_x5", int'(bus.saer_xydata_o), 'hD8);
        xfall();
        chk("r1_xend", int'(bus.saer_xydata_o), 'h4D);
        bus.saer_sxy_i = 1'b0;
        step(4);
        yfall();
        chk("r2_y4", int'(bus.saer_xydata_o), 'hE1);
        bus.saer_sxy_i = 1'b1;
        step(4);
        xfall();
        chk("r2_x9", int'(bus.saer_xydata_o), 'hCC);
        chk("r2_off", int'(bus.saer_off_o), 2);
        chk("r2_on", int'(bus.saer_on_o), 0);
        bus.saer_ynrst_i = 1'b0;
        step(4);
        chk("rewind_xy", int'(bus.saer_xydata_o), 0);
        bus.saer_ynrst_i = 1'b1;
        bus.saer_sxy_i = 1'b0;
        step(2);
        yfall();
        chk("rewind_y3", int'(bus.saer_xydata_o), 'hE2);
        run = 1'b0;
        step(3);
        chk("stop_busy", int'(busy1), 0);
        chk("stop_xy", int'(bus.saer_xydata_o), 0);

        // fill the memory
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
        for (int i = 0; i < 256; i++) wr(8'd0, 8'(i), 4'h0, 4'h0, 1'b1);
        chk("full_evc", int'(evc1), 256);
        chk("full_rdy", int'(bus.wr_rdy_o), 0);
        bus.wr_vld_i = 1'b1;
        step(3);
        bus.wr_vld_i = 1'b0;
        step(1);
        chk("full_hold_evc", int'(evc1), 256);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/dvs_saer_emu.md
DVS_SAER_EMU -- requirements
Module: dvs_saer_emu

Interface
REQ-001 Parameter XDIM, default 52: pixel columns; code index XDIM is XEND; legal range 1..68.
REQ-002 Parameter YDIM, default 66: pixel rows; code index YDIM is YEND; legal range 1..69, YDIM > XDIM not required.
REQ-003 Parameter NCH, default 4: width of each on/off polarity bus.
REQ-004 Parameter DEPTH, default 256: event memory entries, power of two.
REQ-005 Parameter LOOP, default 1: 1 = replay from entry 0 after the last frame; 0 = stop in DONE.
REQ-006 clk_i  in  1: single clock; all state changes on its rising edge.
REQ-007 rst_i  in  1: synchronous, active-high reset.
REQ-008 run_i  in  1: level; 1 = scan the sensor protocol, 0 = idle and loadable.
REQ-009 wr_vld_i / wr_rdy_o  in/out  1: event-load handshake; a write occurs when both are 1.
REQ-010 wr_y_i  in  8, wr_x_i  in  8, wr_on_i  in  NCH, wr_off_i  in  NCH, wr_eof_i  in  1: event fields; eof marks the last event of a frame.
REQ-011 saer_yclk_i, saer_xclk_i, saer_sxy_i, saer_ynrst_i  in  1 each: readout controls from the host.
REQ-012 saer_xydata_o  out  8: 4-of-8 address code.
REQ-013 saer_on_o / saer_off_o  out  NCH each: event polarity data.
REQ-014 ev_count_o  out  log2(DEPTH)+1: number of loaded events.
REQ-015 frame_cnt_o  out  16: frames completed, wrapping.
REQ-016 busy_o / done_o  out  1 each: scanning / finished (LOOP=0 only).

Function
REQ-017 Code index i SHALL map to the i-th 8-bit value with exactly four ones, in descending numeric order (0->0xF0, 1->0xE8, 52->0x4D, 66->0x1D); index >69 SHALL give 0x00.
REQ-018 wr_rdy_o SHALL be 1 only when run_i=0 and ev_count_o<DEPTH; each write stores at ev_count_o and increments it.
REQ-019 The entry at ev_count_o-1 SHALL be treated as eof regardless of its stored flag.
REQ-020 An event SHALL be row-last if it is eof or the next entry has a different y.
REQ-021 Edges SHALL be detected against one-cycle-delayed copies of yclk/xclk; a falling edge is prev=1 and cur=0.
REQ-022 States: IDLE, WAIT_YCLK, YDATA, WAIT_XCLK, XDATA, XEND, YEND, WAIT_LAST_YCLK, DONE.
REQ-023 IDLE->WAIT_YCLK when run_i=1 and ev_count_o>0, with the event pointer at 0; run_i=0 in any state SHALL return to IDLE on the next cycle.
REQ-024 WAIT_YCLK, yclk fall: go to YEND if the frame is exhausted, else go to YDATA.
REQ-025 YDATA: present the y of the current event; on sxy=1 go to WAIT_XCLK.
REQ-026 WAIT_XCLK: on xclk fall go to XDATA.
REQ-027 XDATA: present x, on, off of the current event.
REQ-028 XDATA, xclk fall: if the current event is row-last go to XEND, else advance the pointer and stay in XDATA.
REQ-029 XEND: present code XDIM with on/off=0.
REQ-030 XEND, sxy=0: advance the pointer, set frame-exhausted if the event was eof, and go to WAIT_YCLK.
REQ-031 YEND: present code YDIM; on ynrst=0 go to WAIT_LAST_YCLK.
REQ-032 WAIT_LAST_YCLK, yclk fall: increment frame_cnt_o and clear frame-exhausted. If the pointer wrapped past ev_count_o-1: LOOP=1 -> pointer 0 and WAIT_YCLK; LOOP=0 -> DONE. Otherwise go to WAIT_YCLK.
REQ-033 ynrst=0 in WAIT_YCLK, YDATA, WAIT_XCLK, XDATA or XEND SHALL rewind the pointer to the current frame's first event and go to WAIT_YCLK.
REQ-034 Outputs SHALL be registered: the value changes one cycle after the state/pointer change; saer_xydata_o, saer_on_o and saer_off_o SHALL be 0 outside YDATA/XDATA/XEND/YEND, and on/off SHALL be 0 outside XDATA.
REQ-035 Simultaneous xclk fall and sxy=0 in XDATA: the xclk fall SHALL be handled first.
REQ-036 busy_o=1 outside IDLE/DONE; done_o=1 in DONE only, held until run_i=0.

Reset
REQ-037 On rst_i: state IDLE, ev_count_o=0, frame_cnt_o=0, pointer 0, edge registers 0, all outputs 0, wr_rdy_o=0 during reset; memory contents are not cleared.
REQ-038 rst_i mid-scan SHALL abort immediately; the next run requires reload.

Verification
REQ-039 Load (y=3,x=5,on=1),(y=3,x=7,eof); run; yclk fall -> 0xE2; sxy=1, xclk fall -> 0xD8, on=1; xclk fall -> x7 code; xclk fall -> 0x4D.
REQ-040 Continuing: sxy=0, yclk fall -> 0x1D; ynrst=0, yclk fall -> frame_cnt_o=1, replay from entry 0 (LOOP=1).
REQ-041 LOOP=0 with the same load -> after the last yclk, done_o=1 and outputs 0.
REQ-042 Write DEPTH events -> wr_rdy_o=0; further writes ignored and ev_count_o=DEPTH.
REQ-043 ynrst=0 during XDATA of the second row -> the next yclk fall re-presents the first row's y code.
REQ-044 rst_i asserted in XDATA -> the next cycle shows all outputs 0, state IDLE and ev_count_o=0.
